// File: rtl/alu_op_sequencer.sv
// Command sequencer for the external ALU: single-op EXEC path plus an iterative
// shift-add multiply built on the ALU ADD operation.
module alu_op_sequencer #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic [2:0]        alu_op,
    output logic [DATA_W:0]   alu_a,
    output logic [DATA_W:0]   alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic              busy
);
    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mcand;
    logic [DATA_W-1:0]   mplier;
    logic [CNT_W-1:0]    cnt;
    logic                err;
    logic                alu_zero_unused;

    // The ALU zero flag is ignored: rsp_zero must also cover illegal ops.
    assign alu_zero_unused = alu_zero;
    assign cmd_ready       = (state == IDLE);
    assign busy            = (state != IDLE);

    // The accumulator lives in alu_a; each MUL cycle feeds the ALU sum straight back into it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            alu_op     <= 3'b000;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_op == 3'b101) begin
                            state  <= MUL;
                            err    <= 1'b0;
                            mcand  <= cmd_a;
                            mplier <= cmd_b;
                            cnt    <= '0;
                            alu_op <= 3'b000;
                            alu_a  <= '0;
                            alu_b  <= cmd_b[0] ? {1'b0, cmd_a} : '0;
                        end else if (cmd_op[2:1] == 2'b11) begin
                            state  <= EXEC;
                            err    <= 1'b1;
                            alu_op <= 3'b000;
                            alu_a  <= '0;
                            alu_b  <= '0;
                        end else begin
                            state  <= EXEC;
                            err    <= 1'b0;
                            alu_op <= cmd_op;
                            alu_a  <= {1'b0, cmd_a};
                            alu_b  <= {1'b0, cmd_b};
                        end
                    end
                end
                EXEC: begin
                    state      <= DONE;
                    rsp_valid  <= 1'b1;
                    rsp_result <= err ? '0 : alu_result;
                    rsp_zero   <= err | (alu_result == '0);
                    rsp_err    <= err;
                    alu_op     <= 3'b000;
                    alu_a      <= '0;
                    alu_b      <= '0;
                end
                MUL: begin
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    alu_op <= 3'b000;
                    if (mplier[DATA_W-1:1] == '0 || cnt == CNT_W'(DATA_W - 1)) begin
                        state      <= DONE;
                        rsp_valid  <= 1'b1;
                        rsp_result <= alu_result;
                        rsp_zero   <= (alu_result == '0);
                        rsp_err    <= 1'b0;
                        alu_a      <= '0;
                        alu_b      <= '0;
                    end else begin
                        alu_a <= {1'b0, alu_result};
                        alu_b <= mplier[1] ? {1'b0, mcand << 1} : '0;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench: behavioural ALU model, vector table with a response
// scoreboard, plus back-pressure and mid-multiply reset sequences.
module tb_alu_op_sequencer;
    localparam int unsigned W = 64;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = '0;
    logic [W-1:0] cmd_a = '0;
    logic [W-1:0] cmd_b = '0;
    logic [2:0]   alu_op;
    logic [W:0]   alu_a;
    logic [W:0]   alu_b;
    logic [W-1:0] alu_result;
    logic         alu_zero;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_result;
    logic         rsp_zero;
    logic         rsp_err;
    logic         busy;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         err;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    alu_op_sequencer #(.DATA_W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU
    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'b000:  alu_result = alu_a[W-1:0] + alu_b[W-1:0];
            3'b001:  alu_result = alu_a[W-1:0] - alu_b[W-1:0];
            3'b010:  alu_result = alu_a[W-1:0] & alu_b[W-1:0];
            3'b011:  alu_result = alu_a[W-1:0] | alu_b[W-1:0];
            3'b100:  alu_result = alu_b[W-1:0];
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] b);
        if (op != 3'b101) return 1;
        for (int i = W - 1; i >= 0; i--)
            if (b[i]) return i + 1;
        return 1;
    endfunction

    task automatic drive_cmd(input vec_t v);
        @(negedge clk);
        chk("cmd_ready_idle", {64'd0, cmd_ready}, 65'd1);
        cmd_valid = 1'b1;
        cmd_op = v.op;
        cmd_a = v.a;
        cmd_b = v.b;
        @(posedge clk);
        sb.push_back(v);
        #1;
        cmd_valid = 1'b0;
        chk("busy_after_accept", {64'd0, busy}, 65'd1);
        if (v.op == 3'b101) begin
            chk("mul_alu_a0", alu_a, '0);
            chk("mul_alu_b0", alu_b, v.b[0] ? {1'b0, v.a} : '0);
        end else if (v.err) begin
            chk("ill_alu_op", {62'd0, alu_op}, '0);
            chk("ill_alu_ab", alu_a | alu_b, '0);
        end else begin
            chk("exec_alu_op", {62'd0, alu_op}, {62'd0, v.op});
            chk("exec_alu_a", alu_a, {1'b0, v.a});
            chk("exec_alu_b", alu_b, {1'b0, v.b});
        end
    endtask

    task automatic wait_rsp(input int lat);
        int n = 0;
        vec_t e;
        while (!rsp_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", 65'(n), 65'(lat));
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 65'd1, 65'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_result", {1'b0, rsp_result}, {1'b0, e.res});
            chk("rsp_zero", {64'd0, rsp_zero}, {64'd0, e.res == '0});
            chk("rsp_err", {64'd0, rsp_err}, {64'd0, e.err});
        end
    endtask

    task automatic ack_rsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_dropped", {64'd0, rsp_valid}, 65'd0);
        chk("alu_idle", alu_a | alu_b | {62'd0, alu_op}, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        vecs.push_back('{3'b000, 64'd5, 64'd7, 64'd12, 1'b0});
        vecs.push_back('{3'b001, 64'd9, 64'd9, 64'd0, 1'b0});
        vecs.push_back('{3'b001, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0});
        vecs.push_back('{3'b010, 64'hF0F0, 64'h3C3C, 64'h3030, 1'b0});
        vecs.push_back('{3'b011, 64'hF000, 64'h000F, 64'hF00F, 1'b0});
        vecs.push_back('{3'b100, 64'd77, 64'd0, 64'd0, 1'b0});
        vecs.push_back('{3'b100, 64'd1, 64'hFFFF, 64'hFFFF, 1'b0});
        vecs.push_back('{3'b101, 64'd6, 64'd7, 64'd42, 1'b0});
        vecs.push_back('{3'b101, 64'd5, 64'd0, 64'd0, 1'b0});
        vecs.push_back('{3'b101, 64'h8000_0000_0000_0000, 64'd2, 64'd0, 1'b0});
        vecs.push_back('{3'b101, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0});
        vecs.push_back('{3'b101, 64'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0});
        vecs.push_back('{3'b101, 64'd1000, 64'd1000, 64'd1000000, 1'b0});
        vecs.push_back('{3'b110, 64'd4, 64'd4, 64'd0, 1'b1});
        vecs.push_back('{3'b111, 64'd1, 64'd2, 64'd0, 1'b1});

        #12;
        chk("reset_rsp_valid", {64'd0, rsp_valid}, 65'd0);
        chk("reset_busy", {64'd0, busy}, 65'd0);
        chk("reset_rsp", {rsp_zero, rsp_result} | {64'd0, rsp_err}, '0);
        chk("reset_alu", alu_a | alu_b | {62'd0, alu_op}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("cmd_ready_after_reset", {64'd0, cmd_ready}, 65'd1);

        foreach (vecs[i]) begin
            drive_cmd(vecs[i]);
            wait_rsp(exp_lat(vecs[i].op, vecs[i].b));
            ack_rsp();
        end

        // Back-pressure: response held, commands offered meanwhile must be dropped
        v = '{3'b101, 64'd6, 64'd7, 64'd42, 1'b0};
        drive_cmd(v);
        wait_rsp(3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            cmd_valid = 1'b1;
            cmd_op = 3'b000;
            cmd_a = 64'd1;
            cmd_b = 64'd1;
            chk("hold_valid", {64'd0, rsp_valid}, 65'd1);
            chk("hold_result", {1'b0, rsp_result}, 65'd42);
            chk("hold_cmd_ready", {64'd0, cmd_ready}, 65'd0);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        ack_rsp();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("no_queued_cmd", {63'd0, rsp_valid, busy}, 65'd0);
        end

        // Reset in the middle of a long multiply
        v = '{3'b101, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0};
        drive_cmd(v);
        void'(sb.pop_back());
        repeat (5) @(posedge clk);
        #2;
        chk("mid_mul_busy", {64'd0, busy}, 65'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_busy", {64'd0, busy}, 65'd0);
        chk("async_rst_valid", {64'd0, rsp_valid}, 65'd0);
        chk("async_rst_alu", alu_a | alu_b | {62'd0, alu_op}, '0);
        chk("async_rst_rsp", {rsp_zero, rsp_result} | {64'd0, rsp_err}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) chk("no_rsp_after_reset", 65'd1, 65'd0);
        end
        chk("idle_after_reset", {63'd0, cmd_ready, busy}, 65'd2);
        v = '{3'b000, 64'd100, 64'd23, 64'd123, 1'b0};
        drive_cmd(v);
        wait_rsp(1);
        ack_rsp();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
